// File: rtl/pw_wbuf_pkg.sv
// Shared types and geometry helpers for the ping-pong pointwise weight buffer.
package pw_wbuf_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  typedef logic [7:0] weight_t;

  function automatic int calc_bpl(input int kt, input int beat_bytes);
    return kt / beat_bytes;
  endfunction

  function automatic int calc_total(input int lanes, input int kt, input int beat_bytes);
    return lanes * calc_bpl(kt, beat_bytes);
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pw_wbuf_bank.sv
// One LANES x KT int8 weight bank: lane/beat write port, combinational K-column read.
module pw_wbuf_bank
  import pw_wbuf_pkg::*;
#(
  parameter int LANES      = 32,
  parameter int KT         = 32,
  parameter int BEAT_BYTES = 16,
  parameter int LW         = 5,
  parameter int KW         = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [LW-1:0]           lane,
  input  logic [KW-1:0]           kbase,
  input  logic [BEAT_BYTES*8-1:0] data,
  input  logic [KW-1:0]           rd_k,
  output logic [LANES*8-1:0]      col
);

  weight_t mem [LANES][KT];

  // NOTE: storage has no reset so it maps onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        mem[lane][kbase + KW'(i)] <= data[i*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_col
    assign col[g*8 +: 8] = mem[g][rd_k];
  end

endmodule

// File: rtl/pw_weight_pingpong_buffer.sv
// Ping-pong weight tile buffer: loader fills the shadow bank, commit swaps, registered K-slice reads.
// Optional sticky error flag with err_clr is built when PW_WBUF_ERR_EN is defined.
module pw_weight_pingpong_buffer
  import pw_wbuf_pkg::*;
#(
  parameter int LANES      = 32,
  parameter int KT         = 32,
  parameter int BEAT_BYTES = 16,
  parameter int KW         = clog2_min1(KT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [BEAT_BYTES*8-1:0] w_data,
  input  logic                    w_done,
  output logic                    load_done,
  input  logic                    bank_commit,
  input  logic                    rd_en,
  input  logic [KW-1:0]           rd_k,
  output logic [LANES*8-1:0]      w_vec,
  output logic                    rd_valid,
  output logic                    active_valid,
  output logic                    shadow_full,
  output logic                    busy
`ifdef PW_WBUF_ERR_EN
  ,
  input  logic                    err_clr,
  output logic                    err_sticky
`endif
);

  localparam int BPL = calc_bpl(KT, BEAT_BYTES);
  localparam int LW  = clog2_min1(LANES);
  localparam int BW  = clog2_min1(BPL);

  state_t          state, state_nxt;
  logic            act;
  logic [LW-1:0]   lane_cnt;
  logic [BW-1:0]   beat_cnt;
  logic [KW-1:0]   kbase;
  logic            accept, tile_last, start, load_end, commit_ok, rd_oob;
  logic [LANES*8-1:0] col0, col1;

  assign w_ready   = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD);
  assign accept    = w_valid && w_ready;
  assign tile_last = accept && (lane_cnt == LW'(LANES - 1)) && (beat_cnt == BW'(BPL - 1));
  assign commit_ok = bank_commit && shadow_full;
  assign rd_oob    = int'(rd_k) >= KT;
  assign kbase     = KW'(int'(beat_cnt) * BEAT_BYTES);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load_end  = 1'b0;
    case (state)
      ST_IDLE: if (load_start && !shadow_full) begin
        state_nxt = ST_LOAD;
        start     = 1'b1;
      end
      ST_LOAD: if (tile_last || w_done) begin
        state_nxt = ST_IDLE;
        load_end  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      act          <= 1'b0;
      active_valid <= 1'b0;
      shadow_full  <= 1'b0;
      load_done    <= 1'b0;
      lane_cnt     <= '0;
      beat_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      load_done <= load_end;
      if (start) begin
        lane_cnt <= '0;
        beat_cnt <= '0;
      end else if (accept) begin
        if (beat_cnt == BW'(BPL - 1)) begin
          beat_cnt <= '0;
          lane_cnt <= lane_cnt + LW'(1);
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
      // A load can only end while shadow_full is clear, so these never collide.
      if (load_end) begin
        shadow_full <= 1'b1;
      end else if (commit_ok) begin
        act          <= ~act;
        active_valid <= 1'b1;
        shadow_full  <= 1'b0;
      end
    end
  end

  pw_wbuf_bank #(.LANES(LANES), .KT(KT), .BEAT_BYTES(BEAT_BYTES), .LW(LW), .KW(KW)) u_bank0 (
    .clk(clk), .we(accept && act), .lane(lane_cnt), .kbase(kbase), .data(w_data),
    .rd_k(rd_k), .col(col0)
  );

  pw_wbuf_bank #(.LANES(LANES), .KT(KT), .BEAT_BYTES(BEAT_BYTES), .LW(LW), .KW(KW)) u_bank1 (
    .clk(clk), .we(accept && !act), .lane(lane_cnt), .kbase(kbase), .data(w_data),
    .rd_k(rd_k), .col(col1)
  );

  // Reads use the pre-edge act, so a read alongside a commit sees the old tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      w_vec    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        w_vec <= rd_oob ? '0 : (act ? col1 : col0);
      end
    end
  end

`ifdef PW_WBUF_ERR_EN
  logic err_set;
  assign err_set = (load_end && !tile_last) || (load_start && shadow_full) ||
                   (bank_commit && !shadow_full) || (rd_en && rd_oob);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pw_weight_pingpong_buffer.sv
// Scoreboard bench for pw_weight_pingpong_buffer; checks err_sticky when PW_WBUF_ERR_EN is defined.
module tb_pw_weight_pingpong_buffer;

  localparam int LANES = 32;
  localparam int KT    = 32;
  localparam int BB    = 16;
  localparam int BPL   = KT / BB;
  localparam int KW    = 5;

  logic clk, rst;
  logic load_start, w_valid, w_ready, w_done, load_done, bank_commit, rd_en, rd_valid;
  logic active_valid, shadow_full, busy;
  logic [BB*8-1:0]    w_data;
  logic [KW-1:0]      rd_k;
  logic [LANES*8-1:0] w_vec;

  // Small instance with KT not a power of two so rd_k can exceed KT.
  logic b_load_start, b_w_valid, b_w_ready, b_w_done, b_load_done, b_bank_commit, b_rd_en;
  logic b_rd_valid, b_active_valid, b_shadow_full, b_busy;
  logic [63:0] b_w_data;
  logic [5:0]  b_rd_k;
  logic [15:0] b_w_vec;

`ifdef PW_WBUF_ERR_EN
  logic err_clr, err_sticky, b_err_clr, b_err_sticky;
`endif

  pw_weight_pingpong_buffer #(.LANES(LANES), .KT(KT), .BEAT_BYTES(BB)) u_dut (
    .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_done(w_done), .load_done(load_done), .bank_commit(bank_commit),
    .rd_en(rd_en), .rd_k(rd_k), .w_vec(w_vec), .rd_valid(rd_valid),
    .active_valid(active_valid), .shadow_full(shadow_full), .busy(busy)
`ifdef PW_WBUF_ERR_EN
    , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
  );

  pw_weight_pingpong_buffer #(.LANES(2), .KT(40), .BEAT_BYTES(8)) u_dut_b (
    .clk(clk), .rst(rst), .load_start(b_load_start), .w_valid(b_w_valid), .w_ready(b_w_ready),
    .w_data(b_w_data), .w_done(b_w_done), .load_done(b_load_done), .bank_commit(b_bank_commit),
    .rd_en(b_rd_en), .rd_k(b_rd_k), .w_vec(b_w_vec), .rd_valid(b_rd_valid),
    .active_valid(b_active_valid), .shadow_full(b_shadow_full), .busy(b_busy)
`ifdef PW_WBUF_ERR_EN
    , .err_clr(b_err_clr), .err_sticky(b_err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int ld_pulses = 0;
  int acc_cnt = 0;
  int act_m = 0;
  logic [7:0]         mem_m [2][LANES][KT];
  logic [LANES*8-1:0] sb_q [$];
  logic [LANES*8-1:0] last_exp = '0;

  always @(negedge clk) begin
    if (load_done) ld_pulses++;
    if (w_valid && w_ready) acc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [BB*8-1:0] beat(input int t, input int n);
    logic [BB*8-1:0] d;
    int lane, kb;
    lane = n / BPL;
    kb   = (n % BPL) * BB;
    for (int i = 0; i < BB; i++) d[i*8 +: 8] = 8'((lane * 2 + n % 2 + kb + i + t * 37) & 255);
    return d;
  endfunction

  function automatic logic [LANES*8-1:0] exp_vec(input int k);
    logic [LANES*8-1:0] v;
    v = '0;
    if (k < KT) for (int g = 0; g < LANES; g++) v[g*8 +: 8] = mem_m[act_m][g][k];
    return v;
  endfunction

  task automatic mwrite(input int t, input int n);
    logic [BB*8-1:0] d;
    d = beat(t, n);
    for (int i = 0; i < BB; i++) mem_m[1 - act_m][n / BPL][(n % BPL) * BB + i] = d[i*8 +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: scoreboard push on rd_en, pop and compare after the edge.
  task automatic step();
    logic was_rd;
    was_rd = rd_en;
    if (rd_en) sb_q.push_back(exp_vec(int'(rd_k)));
    tick();
    if (was_rd) begin
      chk("rd_valid", rd_valid, 1);
      last_exp = sb_q.pop_front();
      chk("w_vec", w_vec, last_exp);
    end else begin
      chk("rd_valid_idle", rd_valid, 0);
      chk("w_vec_hold", w_vec, last_exp);
    end
  endtask

  task automatic rd(input int k);
    rd_en = 1'b1; rd_k = KW'(k);
    step();
    rd_en = 1'b0;
  endtask

  task automatic load_tile(input int t, input int nbeats, input bit done_last, input bit reads,
                           input bit expect_end);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < nbeats; n++) begin
      chk("w_ready_in_load", w_ready, 1);
      w_valid = 1'b1;
      w_data  = beat(t, n);
      w_done  = done_last && (n == nbeats - 1);
      if (reads) begin rd_en = 1'b1; rd_k = KW'($urandom_range(0, KT - 1)); end
      mwrite(t, n);
      step();
    end
    w_valid = 1'b0; w_done = 1'b0; rd_en = 1'b0;
    if (expect_end) begin
      chk("load_done_pulse", load_done, 1);
      chk("shadow_full_set", shadow_full, 1);
      chk("busy_after_load", busy, 0);
      chk("w_ready_after_load", w_ready, 0);
      step();
      chk("load_done_one_cycle", load_done, 0);
    end
  endtask

  // Commit with a read in the same cycle, then read again after the swap.
  task automatic commit(input int k);
    bank_commit = 1'b1; rd_en = 1'b1; rd_k = KW'(k);
    step();
    bank_commit = 1'b0; rd_en = 1'b0;
    act_m = 1 - act_m;
    chk("active_valid_commit", active_valid, 1);
    chk("shadow_full_commit", shadow_full, 0);
    rd(k);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    load_start = 0; w_valid = 0; w_data = '0; w_done = 0; bank_commit = 0; rd_en = 0; rd_k = '0;
    b_load_start = 0; b_w_valid = 0; b_w_data = '0; b_w_done = 0; b_bank_commit = 0;
    b_rd_en = 0; b_rd_k = '0;
`ifdef PW_WBUF_ERR_EN
    err_clr = 0; b_err_clr = 0;
`endif
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_shadow_full", shadow_full, 0);
    chk("rst_active_valid", active_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_w_vec", w_vec, 0);
    #9 rst = 1'b0;
    tick();

    // 1: full load, single load_done pulse, commit, lane 3 at k=5.
    base = ld_pulses;
    load_tile(0, 64, 0, 0, 1);
    chk("load_done_count", 32'(ld_pulses - base), 1);
    commit(5);
    chk("lane3_k5", w_vec[3*8 +: 8], 8'd11);

    // 2: second tile loads under continuous reads of tile 1.
    load_tile(1, 64, 0, 1, 1);
    commit(7);

    // 3: w_valid held for 70 cycles, only 64 beats accepted.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    base = acc_cnt;
    for (int c = 0; c < 70; c++) begin
      chk("w_ready_stream", w_ready, (c < 64) ? 1 : 0);
      w_valid = 1'b1;
      w_data  = beat(2, c % 64);
      if (c < 64) mwrite(2, c);
      step();
    end
    w_valid = 1'b0;
    chk("accepted_beats", 32'(acc_cnt - base), 64);
    chk("shadow_full_stream", shadow_full, 1);
    commit(9);

    // 4: short load of 10 beats terminated by w_done.
`ifdef PW_WBUF_ERR_EN
    chk("err_clear_before_short", err_sticky, 0);
`endif
    load_tile(3, 10, 1, 0, 1);
`ifdef PW_WBUF_ERR_EN
    chk("err_short_load", err_sticky, 1);
    step();
    chk("err_sticky_holds", err_sticky, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err_sticky, 0);
`endif
    commit(1);
    rd(17);

    // 5: ignored commit, ignored load_start.
    bank_commit = 1'b1;
    step();
    bank_commit = 1'b0;
    chk("ign_commit_active_valid", active_valid, 1);
    chk("ign_commit_shadow_full", shadow_full, 0);
    rd(2);
    load_tile(4, 64, 0, 0, 1);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ign_start_busy", busy, 0);
    chk("ign_start_w_ready", w_ready, 0);
    chk("ign_start_shadow_full", shadow_full, 1);
    rd(4);
`ifdef PW_WBUF_ERR_EN
    chk("err_ignored_ops", err_sticky, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
`endif
    commit(3);

    // 5b: out-of-range K on an instance with KT=40.
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      b_w_valid = 1'b1;
      for (int i = 0; i < 8; i++) b_w_data[i*8 +: 8] = 8'(n * 8 + i + 1);
      tick();
    end
    b_w_valid = 1'b0;
    tick();
    chk("b_shadow_full", b_shadow_full, 1);
    b_bank_commit = 1'b1;
    tick();
    b_bank_commit = 1'b0;
    b_rd_en = 1'b1; b_rd_k = 6'd39;
    tick();
    chk("b_k39", b_w_vec, 16'h5028);
    b_rd_k = 6'd40;
    tick();
    chk("b_k40_zero", b_w_vec, 16'h0000);
    chk("b_k40_valid", b_rd_valid, 1);
    b_rd_k = 6'd63;
    tick();
    chk("b_k63_zero", b_w_vec, 16'h0000);
    b_rd_en = 1'b0;

    // 6: asynchronous reset at beat 20 of a load.
    load_tile(5, 20, 0, 0, 0);
    chk("busy_mid_load", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_w_ready", w_ready, 0);
    chk("async_shadow_full", shadow_full, 0);
    chk("async_active_valid", active_valid, 0);
    chk("async_w_vec", w_vec, 0);
    #1 rst = 1'b0;
    act_m = 0;
    last_exp = '0;
    sb_q.delete();
    load_tile(6, 64, 0, 0, 1);
    commit(11);
    rd(31);
    rd(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
